cdc_4phase_rr_mux: RTL and testbench

share one 4-phase CDC source port among NumIn requesters; round-robin arbitration, registered output, requester index carried with each item.

Interface
REQ-001 SHALL have parameter NumIn, default 2, number of requesters (>=1).
REQ-002 SHALL have parameter type T, default logic, payload type.
REQ-003 SHALL have localparam IdxWidth, default max(1, clog2(NumIn)), index width.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en_mask_i  input  NumIn  per-requester enable; 0 = never granted.
REQ-007 SHALL have port req_valid_i  input  NumIn  requester valid.
REQ-008 SHALL have port req_ready_o  output  NumIn  requester ready.
REQ-009 SHALL have port req_data_i  input  NumIn x T  requester payload.
REQ-010 SHALL have port cdc_valid_o  output  1  valid toward CDC source port.
REQ-011 SHALL have port cdc_ready_i  input  1  ready from CDC source port.
REQ-012 SHALL have port cdc_data_o  output  T  payload toward CDC.
REQ-013 SHALL have port cdc_idx_o  output  IdxWidth  index of requester owning cdc_data_o.

Function
REQ-014 SHALL drive cdc_valid_o, cdc_data_o, cdc_idx_o directly from flops (out_valid_q, out_data_q, out_idx_q); no combinational path from req_* to cdc_*.
REQ-015 SHALL define load_en = !out_valid_q || cdc_ready_i.
REQ-016 SHALL define candidates = req_valid_i & en_mask_i.
REQ-017 SHALL select grant g = first set candidate scanning rr_ptr_q, rr_ptr_q+1, ... cyclically modulo NumIn.
REQ-018 SHALL assert req_ready_o[g] only when load_en and candidates != 0; all other req_ready_o bits 0.
REQ-019 SHALL, on grant, load out_valid_q=1, out_data_q=req_data_i[g], out_idx_q=g next cycle (latency 1).
REQ-020 SHALL, on grant, set rr_ptr_q = g+1, wrapping NumIn-1 -> 0 (NumIn need not be a power of two).
REQ-021 SHALL, when load_en and candidates == 0, clear out_valid_q; rr_ptr_q, out_data_q, out_idx_q unchanged.
REQ-022 SHALL hold out_valid_q/data/idx stable while out_valid_q && !cdc_ready_i (no retraction, no change).
REQ-023 SHALL sustain one transfer per cycle while cdc_ready_i=1 and candidates != 0.
REQ-024 SHALL never assert req_ready_o for a bit with en_mask_i=0, regardless of req_valid_i.
REQ-025 SHALL leave an already-registered item unaffected by en_mask_i changes.
REQ-026 SHALL, for NumIn=1, keep rr_ptr_q=0 and cdc_idx_o=0.
REQ-027 SHALL grant each continuously valid, enabled requester within NumIn output transfers (no starvation).

Reset
REQ-028 SHALL on rst_ni=0 asynchronously set out_valid_q=0, out_data_q=T'('0), out_idx_q=0, rr_ptr_q=0.
REQ-029 SHALL drop any held, unaccepted item on reset mid-operation; req_ready_o=0 while in reset.

Structure
REQ-030 SHALL place no typedefs in a shared package; IdxWidth stays local.
REQ-031 SHALL implement arbitration inline, without a sub-module; cdc_4phase is instantiated by the integrator, not inside this block.

Verification
REQ-032 SHALL test NumIn=3, all valid/enabled, cdc_ready_i=1 -> cdc_idx_o sequence 0,1,2,0,1,2, one per cycle.
REQ-033 SHALL test cdc_ready_i=0 for 5 cycles with item idx 1, data 0xA5 held -> cdc_* stable; req_ready_o=000.
REQ-034 SHALL test en_mask_i=101, all valid -> idx sequence 0,2,0,2; req_ready_o[1] never 1.
REQ-035 SHALL test rr_ptr_q=2, NumIn=3, only req 1 valid -> grant 1; rr_ptr_q becomes 2; next grant with all valid is 2.
REQ-036 SHALL test rst_ni pulse while cdc_valid_o=1 -> cdc_valid_o=0 immediately; first post-reset grant is lowest valid index.
REQ-037 SHALL test drain: single item, cdc_ready_i=1, no further valid -> cdc_valid_o high exactly 1 cycle.

---
 rtl/cdc_4phase_rr_mux_pkg.sv | 9 +
 rtl/cdc_4phase_rr_mux_if.sv | 32 +++
 rtl/cdc_4phase_rr_mux.sv | 107 ++++++++++
 tb/tb_cdc_4phase_rr_mux.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cdc_4phase_rr_mux_pkg.sv
// Shared helpers for the round-robin mux in front of a 4-phase CDC source port.
package cdc_4phase_rr_mux_pkg;

   // Width of a requester index: clog2(n), but never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
   endfunction

endpackage : cdc_4phase_rr_mux_pkg

// File: rtl/cdc_4phase_rr_mux_if.sv
// Bundle of requester-side and CDC-side signals around cdc_4phase_rr_mux.
interface cdc_4phase_rr_mux_if
   import cdc_4phase_rr_mux_pkg::*;
#(
   parameter int unsigned NumIn = 2,
   parameter type         T     = logic
) ();

   localparam int unsigned IdxWidth = idx_width(NumIn);

   logic [NumIn-1:0]    en_mask;
   logic [NumIn-1:0]    req_valid;
   logic [NumIn-1:0]    req_ready;
   T                    req_data [NumIn];
   logic                cdc_valid;
   logic                cdc_ready;
   T                    cdc_data;
   logic [IdxWidth-1:0] cdc_idx;

   // Environment side: requesters plus the CDC source port's ready.
   modport master (
      output en_mask, req_valid, req_data, cdc_ready,
      input  req_ready, cdc_valid, cdc_data, cdc_idx
   );

   // Mux side.
   modport slave (
      input  en_mask, req_valid, req_data, cdc_ready,
      output req_ready, cdc_valid, cdc_data, cdc_idx
   );

endinterface : cdc_4phase_rr_mux_if

// File: rtl/cdc_4phase_rr_mux.sv
// Round-robin mux sharing one 4-phase CDC source port among NumIn requesters.
// The output stage is a single register slice; the requester index travels
// alongside the payload so the far side can route it back.
module cdc_4phase_rr_mux
   import cdc_4phase_rr_mux_pkg::*;
#(
   parameter int unsigned NumIn    = 2,
   parameter type         T        = logic,
   localparam int unsigned IdxWidth = idx_width(NumIn)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NumIn-1:0]    en_mask_i,
   input  logic [NumIn-1:0]    req_valid_i,
   output logic [NumIn-1:0]    req_ready_o,
   input  T                    req_data_i [NumIn],
   output logic                cdc_valid_o,
   input  logic                cdc_ready_i,
   output T                    cdc_data_o,
   output logic [IdxWidth-1:0] cdc_idx_o
);

   localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumIn - 32'd1);

   logic [NumIn-1:0]    cand_c;
   logic                load_en_c;
   logic                grant_valid_c;
   logic [IdxWidth-1:0] grant_c;
   logic [IdxWidth-1:0] grant_hi_c;
   logic [IdxWidth-1:0] grant_lo_c;
   logic                found_hi_c;
   logic                found_lo_c;

   logic                out_valid_q, out_valid_d;
   T                    out_data_q,  out_data_d;
   logic [IdxWidth-1:0] out_idx_q,   out_idx_d;
   logic [IdxWidth-1:0] rr_ptr_q,    rr_ptr_d;

   // Output slot may take a new item when empty or being drained this cycle.
   assign load_en_c     = !out_valid_q || cdc_ready_i;
   assign cand_c        = req_valid_i & en_mask_i;
   assign grant_valid_c = load_en_c && (cand_c != '0);

   // Round-robin pick: first candidate at or above rr_ptr_q, else lowest candidate.
   always_comb begin
      grant_hi_c = '0;
      grant_lo_c = '0;
      found_hi_c = 1'b0;
      found_lo_c = 1'b0;
      for (int unsigned i = 0; i < NumIn; i++) begin
         if (!found_hi_c && cand_c[IdxWidth'(i)] && (IdxWidth'(i) >= rr_ptr_q)) begin
            found_hi_c = 1'b1;
            grant_hi_c = IdxWidth'(i);
         end
         if (!found_lo_c && cand_c[IdxWidth'(i)]) begin
            found_lo_c = 1'b1;
            grant_lo_c = IdxWidth'(i);
         end
      end
      grant_c = found_hi_c ? grant_hi_c : grant_lo_c;
   end

   // One-hot ready toward the granted requester; held low throughout reset.
   always_comb begin
      req_ready_o = '0;
      if (grant_valid_c && rst_ni) begin
         req_ready_o[grant_c] = 1'b1;
      end
   end

   // Next state of the output slice and the round-robin pointer.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      rr_ptr_d    = rr_ptr_q;
      if (grant_valid_c) begin
         out_valid_d = 1'b1;
         out_data_d  = req_data_i[grant_c];
         out_idx_d   = grant_c;
         rr_ptr_d    = (grant_c == LastIdx) ? '0 : grant_c + IdxWidth'(1);
      end else if (load_en_c) begin
         // Slot drained with nothing to refill: only the valid drops.
         out_valid_d = 1'b0;
      end
   end

   // State registers; reset discards any item still waiting on the CDC port.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_q <= 1'b0;
         out_data_q  <= T'('0);
         out_idx_q   <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign cdc_valid_o = out_valid_q;
   assign cdc_data_o  = out_data_q;
   assign cdc_idx_o   = out_idx_q;

endmodule : cdc_4phase_rr_mux

// File: tb/tb_cdc_4phase_rr_mux.sv
// Directed bench for cdc_4phase_rr_mux with three requesters and byte payloads.
module tb_cdc_4phase_rr_mux;

   localparam int unsigned NumIn = 3;
   localparam int unsigned NVec  = 25;

   logic clk;
   logic rst_n;

   int checks;
   int errors;

   cdc_4phase_rr_mux_if #(.NumIn(NumIn), .T(logic [7:0])) bus ();

   cdc_4phase_rr_mux #(
      .NumIn (NumIn),
      .T     (logic [7:0])
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .en_mask_i   (bus.en_mask),
      .req_valid_i (bus.req_valid),
      .req_ready_o (bus.req_ready),
      .req_data_i  (bus.req_data),
      .cdc_valid_o (bus.cdc_valid),
      .cdc_ready_i (bus.cdc_ready),
      .cdc_data_o  (bus.cdc_data),
      .cdc_idx_o   (bus.cdc_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] mask;
      logic [2:0] valid;
      logic       rdy;
      logic [2:0] exp_ready;
      logic       exp_valid;
      logic [1:0] exp_idx;
      logic [7:0] exp_data;
      logic [1:0] exp_ptr;
   } vec_t;

   vec_t vecs [NVec];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      int hi_cycles;
      checks = 0;
      errors = 0;

      // Requester payloads are fixed; idx 1 carries 0xA5.
      bus.req_data[0] = 8'h10;
      bus.req_data[1] = 8'hA5;
      bus.req_data[2] = 8'h32;

      //            mask    valid   rdy   ready   vld   idx    data   ptr
      vecs[0]  = '{3'b111, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 8'h10, 2'd1};
      vecs[1]  = '{3'b111, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 8'hA5, 2'd2};
      vecs[2]  = '{3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 8'h32, 2'd0};
      vecs[3]  = '{3'b111, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 8'h10, 2'd1};
      vecs[4]  = '{3'b111, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 8'hA5, 2'd2};
      vecs[5]  = '{3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 8'h32, 2'd0};
      vecs[6]  = '{3'b111, 3'b010, 1'b1, 3'b010, 1'b1, 2'd1, 8'hA5, 2'd2};
      vecs[7]  = '{3'b111, 3'b111, 1'b0, 3'b000, 1'b1, 2'd1, 8'hA5, 2'd2};
      vecs[8]  = '{3'b111, 3'b111, 1'b0, 3'b000, 1'b1, 2'd1, 8'hA5, 2'd2};
      vecs[9]  = '{3'b111, 3'b111, 1'b0, 3'b000, 1'b1, 2'd1, 8'hA5, 2'd2};
      vecs[10] = '{3'b111, 3'b111, 1'b0, 3'b000, 1'b1, 2'd1, 8'hA5, 2'd2};
      vecs[11] = '{3'b111, 3'b111, 1'b0, 3'b000, 1'b1, 2'd1, 8'hA5, 2'd2};
      vecs[12] = '{3'b111, 3'b100, 1'b1, 3'b100, 1'b1, 2'd2, 8'h32, 2'd0};
      vecs[13] = '{3'b101, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 8'h10, 2'd1};
      vecs[14] = '{3'b101, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 8'h32, 2'd0};
      vecs[15] = '{3'b101, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 8'h10, 2'd1};
      vecs[16] = '{3'b101, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 8'h32, 2'd0};
      vecs[17] = '{3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 2'd2, 8'h32, 2'd0};
      vecs[18] = '{3'b111, 3'b010, 1'b1, 3'b010, 1'b1, 2'd1, 8'hA5, 2'd2};
      vecs[19] = '{3'b111, 3'b010, 1'b1, 3'b010, 1'b1, 2'd1, 8'hA5, 2'd2};
      vecs[20] = '{3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 8'h32, 2'd0};
      vecs[21] = '{3'b000, 3'b111, 1'b1, 3'b000, 1'b0, 2'd2, 8'h32, 2'd0};
      vecs[22] = '{3'b111, 3'b001, 1'b0, 3'b001, 1'b1, 2'd0, 8'h10, 2'd1};
      vecs[23] = '{3'b000, 3'b111, 1'b0, 3'b000, 1'b1, 2'd0, 8'h10, 2'd1};
      vecs[24] = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 2'd0, 8'h10, 2'd1};

      // Reset with requesters already valid: nothing may be granted.
      rst_n         = 1'b0;
      bus.en_mask   = 3'b111;
      bus.req_valid = 3'b111;
      bus.cdc_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset valid", 32'(bus.cdc_valid), 32'd0);
      check("reset idx",   32'(bus.cdc_idx),   32'd0);
      check("reset data",  32'(bus.cdc_data),  32'd0);
      check("reset ready", 32'(bus.req_ready), 32'd0);
      check("reset ptr",   32'(dut.rr_ptr_q),  32'd0);

      @(negedge clk);
      rst_n = 1'b1;

      // Table: drive at negedge, check ready combinationally, outputs after posedge.
      for (int i = 0; i < int'(NVec); i++) begin
         if (i != 0) @(negedge clk);
         bus.en_mask   = vecs[i].mask;
         bus.req_valid = vecs[i].valid;
         bus.cdc_ready = vecs[i].rdy;
         #1;
         check($sformatf("row%0d ready", i), 32'(bus.req_ready), 32'(vecs[i].exp_ready));
         @(posedge clk);
         #1;
         check($sformatf("row%0d valid", i), 32'(bus.cdc_valid), 32'(vecs[i].exp_valid));
         check($sformatf("row%0d idx", i),   32'(bus.cdc_idx),   32'(vecs[i].exp_idx));
         check($sformatf("row%0d data", i),  32'(bus.cdc_data),  32'(vecs[i].exp_data));
         check($sformatf("row%0d ptr", i),   32'(dut.rr_ptr_q),  32'(vecs[i].exp_ptr));
      end

      // Drain: one item, then nothing; valid must be high for exactly one cycle.
      @(negedge clk);
      bus.en_mask   = 3'b111;
      bus.req_valid = 3'b001;
      bus.cdc_ready = 1'b1;
      #1;
      check("drain ready", 32'(bus.req_ready), 32'b001);
      hi_cycles = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         if (bus.cdc_valid) hi_cycles++;
         if (c == 0) check("drain idx", 32'(bus.cdc_idx), 32'd0);
         @(negedge clk);
         bus.req_valid = 3'b000;
      end
      check("drain high cycles", 32'(hi_cycles), 32'd1);

      // Reset pulse while an item is held toward a stalled CDC port.
      bus.req_valid = 3'b010;
      bus.cdc_ready = 1'b0;
      @(posedge clk);
      #1;
      check("pre-rst valid", 32'(bus.cdc_valid), 32'd1);
      check("pre-rst idx",   32'(bus.cdc_idx),   32'd1);
      @(negedge clk);
      bus.req_valid = 3'b111;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst async valid", 32'(bus.cdc_valid), 32'd0);
      check("rst async idx",   32'(bus.cdc_idx),   32'd0);
      check("rst async data",  32'(bus.cdc_data),  32'd0);
      check("rst async ready", 32'(bus.req_ready), 32'd0);
      check("rst async ptr",   32'(dut.rr_ptr_q),  32'd0);
      @(posedge clk);
      #1;
      check("rst held valid", 32'(bus.cdc_valid), 32'd0);
      @(negedge clk);
      rst_n         = 1'b1;
      bus.req_valid = 3'b110;
      bus.cdc_ready = 1'b1;
      #1;
      check("post-rst ready", 32'(bus.req_ready), 32'b010);
      @(posedge clk);
      #1;
      check("post-rst valid", 32'(bus.cdc_valid), 32'd1);
      check("post-rst idx",   32'(bus.cdc_idx),   32'd1);
      check("post-rst data",  32'(bus.cdc_data),  32'hA5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_cdc_4phase_rr_mux
